datapath: RTL and testbench

- 32-bit single-bus Mini SRC datapath.
- Contains:
  - register file R0–R15
  - PC, IR, MAR, MDR, Y, 64-bit Z (Zhigh/Zlow), HI, LO
  - bus multiplexer
  - combinational ALU
- All control signals come from an external control unit or bench, one strobe per register transfer.
- The datapath does no instruction decoding; IR is only stored and exported.

---
 rtl/datapath_pkg.sv | 29 ++
 rtl/datapath_alu.sv | 60 ++++++
 rtl/datapath.sv | 95 +++++++++
 tb/tb_datapath.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared constants for the Mini SRC datapath: bus width, ALU op indices, bus-source indices.
// The divider is present only when DATAPATH_DIV_EN is defined (see datapath_alu).
package datapath_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = $clog2(WIDTH);

    // Bit positions inside the one-hot ALU op vector; lower index wins.
    typedef enum logic [3:0] {
        OP_INC, OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
        OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT
    } alu_op_e;
    localparam int NUM_OPS = 14;

    // Bus-source indices; R0..R15 occupy 0..15, lower index wins.
    localparam int NUM_GPR = 16;
    localparam int SRC_HI  = 16;
    localparam int SRC_LO  = 17;
    localparam int SRC_ZHI = 18;
    localparam int SRC_ZLO = 19;
    localparam int SRC_PC  = 20;
    localparam int SRC_MDR = 21;
    localparam int NUM_SRC = 22;

    function automatic logic [2*WIDTH-1:0] zext(input logic [WIDTH-1:0] v);
        return {{WIDTH{1'b0}}, v};
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational Mini SRC ALU, A = Y, B = bus, prioritised one-hot op select, 64-bit result.
// Latency: zero cycles; no backpressure. Divider built only with DATAPATH_DIV_EN, otherwise DIV yields 0.
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [NUM_OPS-1:0] op,
    output logic [2*WIDTH-1:0] result
);

    logic [SHW-1:0]            sh;
    logic [SHW:0]              sh_c;
    logic signed [WIDTH-1:0]   a_s;
    logic [WIDTH-1:0]          sra, ror, rol;
    logic signed [2*WIDTH-1:0] ma, mb, prod;
    logic [2*WIDTH-1:0]        div_res;

    assign sh   = b[SHW-1:0];
    assign sh_c = (SHW+1)'(WIDTH) - {1'b0, sh};
    assign a_s  = a;
    assign sra  = a_s >>> sh;
    // A shift by the full width yields 0, so a zero rotate amount falls out naturally.
    assign ror  = (a >> sh) | (a << sh_c);
    assign rol  = (a << sh) | (a >> sh_c);

    assign ma   = {{WIDTH{a[WIDTH-1]}}, a};
    assign mb   = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod = ma * mb;

`ifdef DATAPATH_DIV_EN
    logic signed [WIDTH-1:0] sa, sb, quot, rem;
    assign sa      = a;
    assign sb      = b;
    assign quot    = sa / sb;
    assign rem     = sa % sb;
    assign div_res = (b == '0) ? {a, {WIDTH{1'b1}}} : {rem, quot};
`else
    assign div_res = '0;
`endif

    always_comb begin
        result = '0;
        if      (op[OP_INC])  result = zext(b + WIDTH'(1));
        else if (op[OP_AND])  result = zext(a & b);
        else if (op[OP_OR])   result = zext(a | b);
        else if (op[OP_ADD])  result = zext(a + b);
        else if (op[OP_SUB])  result = zext(a - b);
        else if (op[OP_MUL])  result = prod;
        else if (op[OP_DIV])  result = div_res;
        else if (op[OP_SHR])  result = zext(a >> sh);
        else if (op[OP_SHRA]) result = zext(sra);
        else if (op[OP_SHL])  result = zext(a << sh);
        else if (op[OP_ROR])  result = zext(ror);
        else if (op[OP_ROL])  result = zext(rol);
        else if (op[OP_NEG])  result = zext(WIDTH'(0) - a);
        else if (op[OP_NOT])  result = zext(~a);
    end

endmodule

// File: rtl/datapath.sv
// Mini SRC single-bus datapath: R0-R15, PC, IR, MAR, MDR, Y, Z, HI, LO, bus mux, ALU (divider via DATAPATH_DIV_EN).
// Latency: one Clock per register transfer; no backpressure, every strobe takes effect on the edge.
module datapath
    import datapath_pkg::*;
(
    input  logic             Clock,
    input  logic             Clear,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
    input  logic R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic HIout,  LOout,  Zhighout, Zlowout, PCout, MDRout,
    input  logic R0in,   R1in,   R2in,   R3in,   R4in,   R5in,   R6in,   R7in,
    input  logic R8in,   R9in,   R10in,  R11in,  R12in,  R13in,  R14in,  R15in,
    input  logic HIin,   LOin,   PCin,   IRin,   MARin,  MDRin,  Yin,    Zin,
    input  logic Read,
    input  logic IncPC,
    input  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] IRq,
    output logic [WIDTH-1:0] MARq
);

    logic [WIDTH-1:0]   rf [NUM_GPR];
    logic [WIDTH-1:0]   pc, ir, mar, mdr, y, zhi, zlo, hi, lo;
    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   src_val [NUM_SRC];
    logic [NUM_SRC-1:0] src_en;
    logic [NUM_GPR-1:0] r_in;
    logic [NUM_OPS-1:0] alu_op;
    logic [2*WIDTH-1:0] alu_res;

    assign src_en = {MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                     R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
    assign r_in   = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign alu_op = {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, ADD, OR, AND, IncPC};

    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) src_val[i] = rf[i];
        src_val[SRC_HI]  = hi;
        src_val[SRC_LO]  = lo;
        src_val[SRC_ZHI] = zhi;
        src_val[SRC_ZLO] = zlo;
        src_val[SRC_PC]  = pc;
        src_val[SRC_MDR] = mdr;
    end

    // Scan from lowest priority upward so the lowest enabled index ends up driving the bus.
    always_comb begin
        bus = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_en[i]) bus = src_val[i];
        end
    end

    datapath_alu u_alu (
        .a      (y),
        .b      (bus),
        .op     (alu_op),
        .result (alu_res)
    );

    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < NUM_GPR; i++) rf[i] <= '0;
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            y   <= '0;
            zhi <= '0;
            zlo <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (r_in[i]) rf[i] <= bus;
            end
            if (PCin)  pc  <= bus;
            if (IRin)  ir  <= bus;
            if (MARin) mar <= bus;
            if (MDRin) mdr <= Read ? Mdatain : bus;
            if (Yin)   y   <= bus;
            if (HIin)  hi  <= bus;
            if (LOin)  lo  <= bus;
            if (Zin)   {zhi, zlo} <= alu_res;
        end
    end

    assign BusMuxOut = bus;
    assign IRq       = ir;
    assign MARq      = mar;

endmodule

// File: tb/tb_datapath.sv
// Randomised and directed bench for datapath against a behavioural register-transfer model.
module tb_datapath;
    import datapath_pkg::*;

    localparam logic [7:0] L_HI = 8'h01, L_LO = 8'h02, L_PC = 8'h04, L_IR = 8'h08;
    localparam logic [7:0] L_MAR = 8'h10, L_MDR = 8'h20, L_Y = 8'h40, L_Z = 8'h80;

    logic               clk;
    logic               clear;
    logic [31:0]        mdatain;
    logic [NUM_SRC-1:0] src_out;
    logic [15:0]        r_in;
    logic [7:0]         ld;
    logic [13:0]        op;
    logic               rd;
    logic [31:0]        bus_q, ir_q, mar_q;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo, m_hi, m_lo;

    datapath dut (
        .Clock(clk), .Clear(clear), .Mdatain(mdatain),
        .R0out(src_out[0]),   .R1out(src_out[1]),   .R2out(src_out[2]),   .R3out(src_out[3]),
        .R4out(src_out[4]),   .R5out(src_out[5]),   .R6out(src_out[6]),   .R7out(src_out[7]),
        .R8out(src_out[8]),   .R9out(src_out[9]),   .R10out(src_out[10]), .R11out(src_out[11]),
        .R12out(src_out[12]), .R13out(src_out[13]), .R14out(src_out[14]), .R15out(src_out[15]),
        .HIout(src_out[16]),  .LOout(src_out[17]),  .Zhighout(src_out[18]), .Zlowout(src_out[19]),
        .PCout(src_out[20]),  .MDRout(src_out[21]),
        .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
        .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
        .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .HIin(ld[0]), .LOin(ld[1]), .PCin(ld[2]), .IRin(ld[3]),
        .MARin(ld[4]), .MDRin(ld[5]), .Yin(ld[6]), .Zin(ld[7]),
        .Read(rd), .IncPC(op[0]),
        .AND(op[1]), .OR(op[2]), .ADD(op[3]), .SUB(op[4]), .MUL(op[5]), .DIV(op[6]),
        .SHR(op[7]), .SHRA(op[8]), .SHL(op[9]), .ROR(op[10]), .ROL(op[11]),
        .NEG(op[12]), .NOT(op[13]),
        .BusMuxOut(bus_q), .IRq(ir_q), .MARq(mar_q)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] src_value(input int i);
        if (i < 16) return m_r[i];
        case (i)
            SRC_HI:  return m_hi;
            SRC_LO:  return m_lo;
            SRC_ZHI: return m_zhi;
            SRC_ZLO: return m_zlo;
            SRC_PC:  return m_pc;
            default: return m_mdr;
        endcase
    endfunction

    function automatic logic [31:0] model_bus();
        for (int i = 0; i < NUM_SRC; i++)
            if (src_out[i]) return src_value(i);
        return 32'h0;
    endfunction

    function automatic int first_op(input logic [13:0] v);
        for (int i = 0; i < 14; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [13:0] v);
        logic [31:0] t;
        longint      sa, sb, q, r;
        int          s;
        s  = int'(b[4:0]);
        sa = $signed(a);
        sb = $signed(b);
        t  = a;
        case (first_op(v))
            0:  begin t = b + 32'd1; return {32'h0, t}; end
            1:  return {32'h0, a & b};
            2:  return {32'h0, a | b};
            3:  begin t = a + b; return {32'h0, t}; end
            4:  begin t = a - b; return {32'h0, t}; end
            5:  return 64'(sa * sb);
            6: begin
`ifdef DATAPATH_DIV_EN
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa - q * sb;
                return {r[31:0], q[31:0]};
`else
                return 64'h0;
`endif
            end
            7:  return {32'h0, a >> s};
            8:  begin for (int i = 0; i < s; i++) t = {t[31], t[31:1]}; return {32'h0, t}; end
            9:  return {32'h0, a << s};
            10: begin for (int i = 0; i < s; i++) t = {t[0], t[31:1]}; return {32'h0, t}; end
            11: begin for (int i = 0; i < s; i++) t = {t[30:0], t[31]}; return {32'h0, t}; end
            12: begin t = 32'h0 - a; return {32'h0, t}; end
            13: return {32'h0, ~a};
            default: return 64'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model_update
        logic [31:0] b;
        logic [63:0] z;
        b = model_bus();
        z = model_alu(m_y, b, op);
        if (clear) begin
            for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
            {m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo, m_hi, m_lo} = '0;
        end else begin
            for (int i = 0; i < 16; i++) if (r_in[i]) m_r[i] = b;
            if (ld[0]) m_hi  = b;
            if (ld[1]) m_lo  = b;
            if (ld[2]) m_pc  = b;
            if (ld[3]) m_ir  = b;
            if (ld[4]) m_mar = b;
            if (ld[5]) m_mdr = rd ? mdatain : b;
            if (ld[6]) m_y   = b;
            if (ld[7]) {m_zhi, m_zlo} = z;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("bus", bus_q, model_bus());
            check("IRq", ir_q, m_ir);
            check("MARq", mar_q, m_mar);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        src_out = '0; r_in = '0; ld = '0; op = '0; rd = 0; clear = 0;
    endtask

    task automatic step(input int src, input logic [15:0] rin, input logic [7:0] l,
                        input int opi, input logic r, input logic c);
        idle();
        if (src >= 0) src_out[src] = 1'b1;
        r_in = rin; ld = l; rd = r; clear = c;
        if (opi >= 0) op[opi] = 1'b1;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic peek(input int src, input string name, input logic [31:0] exp);
        idle();
        if (src >= 0) src_out[src] = 1'b1;
        #1;
        check(name, bus_q, exp);
        idle();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] val);
        mdatain = val;
        step(-1, 16'h0, L_MDR, -1, 1'b1, 1'b0);
        step(SRC_MDR, 16'h1 << idx, 8'h0, -1, 1'b0, 1'b0);
    endtask

    task automatic run_op(input int rx, input int ry, input int opi, input int dst);
        step(rx, 16'h0, L_Y, -1, 1'b0, 1'b0);
        step(ry, 16'h0, L_Z, opi, 1'b0, 1'b0);
        step(SRC_ZLO, 16'h1 << dst, 8'h0, -1, 1'b0, 1'b0);
    endtask

    task automatic run_muldiv(input int rx, input int ry, input int opi);
        step(rx, 16'h0, L_Y, -1, 1'b0, 1'b0);
        step(ry, 16'h0, L_Z, opi, 1'b0, 1'b0);
        step(SRC_ZLO, 16'h0, L_LO, -1, 1'b0, 1'b0);
        step(SRC_ZHI, 16'h0, L_HI, -1, 1'b0, 1'b0);
    endtask

    initial begin
        int k;
        idle();
        mdatain = 32'h0;
        for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
        {m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo, m_hi, m_lo} = '0;

        step(-1, 16'hFFFF, 8'hFF, -1, 1'b1, 1'b1);
        chk_en = 1;
        peek(-1, "reset_bus_idle", 32'h0);
        peek(SRC_PC, "reset_pc", 32'h0);
        peek(5, "reset_r5", 32'h0);
        check("reset_ir", ir_q, 32'h0);

        // Instruction fetch
        mdatain = 32'h2A2B8000;
        step(SRC_PC, 16'h0, L_MAR | L_Z, OP_INC, 1'b0, 1'b0);
        step(SRC_ZLO, 16'h0, L_PC | L_MDR, -1, 1'b1, 1'b0);
        step(SRC_MDR, 16'h0, L_IR, -1, 1'b0, 1'b0);
        check("fetch_ir", ir_q, 32'h2A2B8000);
        check("fetch_mar", mar_q, 32'h0);
        peek(SRC_PC, "fetch_pc", 32'h1);

        load_reg(3, 32'h22);
        load_reg(7, 32'h4);
        run_op(3, 7, OP_AND,  4); peek(4, "and",  32'h0);
        run_op(3, 7, OP_OR,   4); peek(4, "or",   32'h26);
        run_op(3, 7, OP_ADD,  4); peek(4, "add",  32'h26);
        run_op(3, 7, OP_SUB,  4); peek(4, "sub",  32'h1E);
        run_op(3, 7, OP_SHR,  4); peek(4, "shr",  32'h2);
        run_op(3, 7, OP_SHRA, 4); peek(4, "shra", 32'h2);
        run_op(3, 7, OP_SHL,  4); peek(4, "shl",  32'h220);
        run_op(3, 7, OP_ROR,  4); peek(4, "ror",  32'h20000002);
        run_op(3, 7, OP_ROL,  4); peek(4, "rol",  32'h220);

        load_reg(2, 32'h0F000022);
        load_reg(6, 32'h4);
        run_muldiv(2, 6, OP_MUL);
        peek(SRC_LO, "mul_lo", 32'h3C000088);
        peek(SRC_HI, "mul_hi", 32'h0);
        run_muldiv(2, 6, OP_DIV);
`ifdef DATAPATH_DIV_EN
        peek(SRC_LO, "div_lo", 32'h03C00008);
        peek(SRC_HI, "div_hi", 32'h2);
`else
        peek(SRC_LO, "div_lo", 32'h0);
        peek(SRC_HI, "div_hi", 32'h0);
`endif
        load_reg(6, 32'h0);
        run_muldiv(2, 6, OP_DIV);
`ifdef DATAPATH_DIV_EN
        peek(SRC_LO, "div0_lo", 32'hFFFFFFFF);
        peek(SRC_HI, "div0_hi", 32'h0F000022);
`else
        peek(SRC_LO, "div0_lo", 32'h0);
        peek(SRC_HI, "div0_hi", 32'h0);
`endif

        load_reg(0, 32'h0);
        run_op(0, 0, OP_NEG, 5); peek(5, "neg0", 32'h0);
        run_op(0, 0, OP_NOT, 5); peek(5, "not0", 32'hFFFFFFFF);
        load_reg(0, 32'h5);
        run_op(0, 0, OP_NEG, 5); peek(5, "neg5", 32'hFFFFFFFB);

        // R3 must win over MDR (which currently holds 5)
        idle();
        src_out[3] = 1'b1;
        src_out[SRC_MDR] = 1'b1;
        #1;
        check("prio_r3_over_mdr", bus_q, 32'h22);
        idle();

        step(3, 16'h0010, 8'h0, -1, 1'b0, 1'b1);
        peek(4, "clear_beats_r4in", 32'h0);
        peek(3, "clear_r3", 32'h0);

        for (int n = 0; n < 1500; n++) begin
            idle();
            for (int i = 0; i < NUM_SRC; i++) src_out[i] = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 16; i++) r_in[i] = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 8; i++) ld[i] = ($urandom_range(0, 3) == 0);
            k = $urandom_range(0, 20);
            if (k < NUM_OPS) op[k] = 1'b1;
            if ($urandom_range(0, 5) == 0) op[$urandom_range(0, 13)] = 1'b1;
            rd = ($urandom_range(0, 1) == 1);
            mdatain = $urandom;
            clear = ($urandom_range(0, 39) == 0);
            // Signed overflow of INT_MIN / -1 has no defined result; steer around it.
            if (first_op(op) == OP_DIV && m_y == 32'h80000000 && model_bus() == 32'hFFFFFFFF)
                op = '0;
            @(posedge clk);
            #1;
        end
        idle();
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
